// File: rtl/sum_pkg.sv
// Shared definitions for the windowed accumulator: default widths, the FSM
// state type and the saturating add used for the running sum.
package sum_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ACC_W  = 24;
    localparam int unsigned DEF_CNT_W  = 8;
    // Widest accumulator sat_add supports; ACC_W must not exceed this.
    localparam int unsigned ACC_MAX_W  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Returns {sum, ovf}: sum clamps to 2^acc_w-1 when the true sum exceeds it.
    function automatic logic [ACC_MAX_W:0] sat_add(
        input logic [ACC_MAX_W-1:0] acc,
        input logic [ACC_MAX_W-1:0] data,
        input int unsigned          acc_w
    );
        logic [ACC_MAX_W:0] sum;
        logic [ACC_MAX_W:0] limit;
        sum   = {1'b0, acc} + {1'b0, data};
        limit = ((ACC_MAX_W+1)'(1) << acc_w) - (ACC_MAX_W+1)'(1);
        if (sum > limit) begin
            return {limit[ACC_MAX_W-1:0], 1'b1};
        end
        return {sum[ACC_MAX_W-1:0], 1'b0};
    endfunction

endpackage

// File: rtl/sum_window_acc_if.sv
// Sample input handshake, window control and result output bundle.
//   clear, win_len            : window control (master -> slave)
//   in_valid/in_ready/in_data : sample stream into the accumulator
//   out_valid/out_ready/out_* : per-window result
interface sum_window_acc_if
    import sum_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ACC_W  = DEF_ACC_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
);

    logic              clear;
    logic [CNT_W-1:0]  win_len;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [DATA_W-1:0] out_max;
    logic [DATA_W-1:0] out_min;
    logic [CNT_W-1:0]  out_cnt;
    logic              out_ovf;

    modport master (
        output clear, win_len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_max, out_min, out_cnt, out_ovf
    );

    modport slave (
        input  clear, win_len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_max, out_min, out_cnt, out_ovf
    );

endinterface

// File: rtl/sum_minmax_track.sv
// Running max/min tracker. init restarts both with data, upd folds data in
// (unsigned, ties leave the value unchanged). Outputs are the next values so
// the caller can capture them on the same edge that accepts the sample.
//   clk, rst_n   : clock, async active-low reset
//   init, upd    : restart / update strobes
//   data         : sample
//   max_c, min_c : values after this cycle's update
module sum_minmax_track #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init,
    input  logic              upd,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] max_c,
    output logic [DATA_W-1:0] min_c
);

    logic [DATA_W-1:0] max_q;
    logic [DATA_W-1:0] min_q;

    // Next max/min
    always_comb begin
        max_c = max_q;
        min_c = min_q;
        if (init) begin
            max_c = data;
            min_c = data;
        end else if (upd) begin
            if (data > max_q) max_c = data;
            if (data < min_q) min_c = data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= '0;
            min_q <= '1;
        end else begin
            max_q <= max_c;
            min_q <= min_c;
        end
    end

endmodule

// File: rtl/sum_window_acc.sv
// Windowed accumulator: sums a programmable number of unsigned samples and
// reports sum (saturating), max, min, count and overflow per window.
//   clk, rst_n : clock, async active-low reset
//   bus        : sum_window_acc_if slave (control, sample in, result out)
module sum_window_acc
    import sum_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ACC_W  = DEF_ACC_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    sum_window_acc_if.slave  bus
);

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0]  len;
    logic [CNT_W-1:0]  len_d;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  len_eff;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_d;
    logic              ovf;
    logic              ovf_d;
    logic              mm_init;
    logic              mm_upd;
    logic              load_out;
    logic              in_xfer;
    logic              out_xfer;
    logic [DATA_W-1:0] max_c;
    logic [DATA_W-1:0] min_c;

    logic              in_ready_r;
    logic              out_valid_r;
    logic [ACC_W-1:0]  out_sum_r;
    logic [DATA_W-1:0] out_max_r;
    logic [DATA_W-1:0] out_min_r;
    logic [CNT_W-1:0]  out_cnt_r;
    logic              out_ovf_r;

    // clear blocks acceptance in the same cycle
    assign in_xfer  = bus.in_valid && in_ready_r && !bus.clear;
    assign out_xfer = out_valid_r && bus.out_ready;
    assign cnt_inc  = cnt + CNT_W'(1);
    assign len_eff  = (bus.win_len == '0) ? CNT_W'(1) : bus.win_len;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state
    always_comb begin
        state_nxt = state;
        if (bus.clear) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (in_xfer) state_nxt = (len_eff == CNT_W'(1)) ? HOLD : ACCUM;
                ACCUM:   if (in_xfer && (cnt_inc == len)) state_nxt = HOLD;
                HOLD:    if (out_xfer) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath next values and strobes
    always_comb begin
        len_d    = len;
        acc_d    = acc;
        cnt_d    = cnt;
        ovf_d    = ovf;
        mm_init  = 1'b0;
        mm_upd   = 1'b0;
        load_out = 1'b0;
        if (in_xfer) begin
            if (state == IDLE) begin
                len_d   = len_eff;
                acc_d   = ACC_W'(bus.in_data);
                cnt_d   = CNT_W'(1);
                ovf_d   = 1'b0;
                mm_init = 1'b1;
            end else if (state == ACCUM) begin
                acc_d  = ACC_W'(sat_add(ACC_MAX_W'(acc), ACC_MAX_W'(bus.in_data), ACC_W) >> 1);
                ovf_d  = ovf | 1'(sat_add(ACC_MAX_W'(acc), ACC_MAX_W'(bus.in_data), ACC_W));
                cnt_d  = cnt_inc;
                mm_upd = 1'b1;
            end
        end
        // Result registers only change when a window completes
        load_out = (state_nxt == HOLD) && (state != HOLD);
    end

    sum_minmax_track #(
        .DATA_W (DATA_W)
    ) u_minmax (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (mm_init),
        .upd   (mm_upd),
        .data  (bus.in_data),
        .max_c (max_c),
        .min_c (min_c)
    );

    // Window and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len         <= '0;
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_sum_r   <= '0;
            out_max_r   <= '0;
            out_min_r   <= '1;
            out_cnt_r   <= '0;
            out_ovf_r   <= 1'b0;
        end else begin
            len         <= len_d;
            acc         <= acc_d;
            cnt         <= cnt_d;
            ovf         <= ovf_d;
            in_ready_r  <= (state_nxt != HOLD);
            out_valid_r <= (state_nxt == HOLD);
            if (load_out) begin
                out_sum_r <= acc_d;
                out_max_r <= max_c;
                out_min_r <= min_c;
                out_cnt_r <= cnt_d;
                out_ovf_r <= ovf_d;
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_sum   = out_sum_r;
    assign bus.out_max   = out_max_r;
    assign bus.out_min   = out_min_r;
    assign bus.out_cnt   = out_cnt_r;
    assign bus.out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_sum_window_acc.sv
// Bench for sum_window_acc: a 24-bit and a 16-bit accumulator instance share
// the same stimulus so saturation is exercised alongside normal windows.
module tb_sum_window_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  win_len;
    logic [15:0] in_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sum_window_acc_if #(.DATA_W(16), .ACC_W(24), .CNT_W(8)) b0 ();
    sum_window_acc_if #(.DATA_W(16), .ACC_W(16), .CNT_W(8)) b1 ();

    assign b0.clear     = clear;
    assign b0.win_len   = win_len;
    assign b0.in_valid  = in_valid;
    assign b0.in_data   = in_data;
    assign b0.out_ready = out_ready;
    assign b1.clear     = clear;
    assign b1.win_len   = win_len;
    assign b1.in_valid  = in_valid;
    assign b1.in_data   = in_data;
    assign b1.out_ready = out_ready;

    sum_window_acc #(.DATA_W(16), .ACC_W(24), .CNT_W(8)) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    sum_window_acc #(.DATA_W(16), .ACC_W(16), .CNT_W(8)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    typedef struct {
        logic [7:0]       len;
        int               n;
        logic [3:0][15:0] s;
        logic [31:0]      sum24;
        logic [31:0]      sum16;
        logic [15:0]      mx;
        logic [15:0]      mn;
        logic [7:0]       cn;
        logic             ovf24;
        logic             ovf16;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flow(input string tag, input logic vld, input logic rdy);
        chk({tag, ".out_valid0"}, 32'(b0.out_valid), 32'(vld));
        chk({tag, ".out_valid1"}, 32'(b1.out_valid), 32'(vld));
        chk({tag, ".in_ready0"},  32'(b0.in_ready),  32'(rdy));
        chk({tag, ".in_ready1"},  32'(b1.in_ready),  32'(rdy));
    endtask

    task automatic check_res(input string tag, input logic [31:0] s0, input logic [31:0] s1,
                             input logic [15:0] mx, input logic [15:0] mn, input logic [7:0] cn,
                             input logic o0, input logic o1);
        chk_flow(tag, 1'b1, 1'b0);
        chk({tag, ".sum0"}, 32'(b0.out_sum), s0);
        chk({tag, ".sum1"}, 32'(b1.out_sum), s1);
        chk({tag, ".max0"}, 32'(b0.out_max), 32'(mx));
        chk({tag, ".max1"}, 32'(b1.out_max), 32'(mx));
        chk({tag, ".min0"}, 32'(b0.out_min), 32'(mn));
        chk({tag, ".min1"}, 32'(b1.out_min), 32'(mn));
        chk({tag, ".cnt0"}, 32'(b0.out_cnt), 32'(cn));
        chk({tag, ".cnt1"}, 32'(b1.out_cnt), 32'(cn));
        chk({tag, ".ovf0"}, 32'(b0.out_ovf), 32'(o0));
        chk({tag, ".ovf1"}, 32'(b1.out_ovf), 32'(o1));
    endtask

    // Presents n samples back to back; returns just after the last accepting edge.
    task automatic feed(input string tag, input logic [7:0] len, input int n, input logic [3:0][15:0] s);
        win_len = len;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = s[i];
            chk({tag, ".in_ready0_pre"}, 32'(b0.in_ready), 32'd1);
            chk({tag, ".in_ready1_pre"}, 32'(b1.in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    initial begin
        vecs[0] = '{8'd4, 4, {16'd30, 16'd24, 16'd18, 16'd12}, 32'd84, 32'd84, 16'd30, 16'd12, 8'd4, 1'b0, 1'b0};
        vecs[1] = '{8'd0, 1, {16'd0, 16'd0, 16'd0, 16'd60}, 32'd60, 32'd60, 16'd60, 16'd60, 8'd1, 1'b0, 1'b0};
        vecs[2] = '{8'd3, 3, {16'd0, 16'd5, 16'd5, 16'd5}, 32'd15, 32'd15, 16'd5, 16'd5, 8'd3, 1'b0, 1'b0};
        vecs[3] = '{8'd2, 2, {16'd0, 16'd0, 16'd7, 16'd100}, 32'd107, 32'd107, 16'd100, 16'd7, 8'd2, 1'b0, 1'b0};
        vecs[4] = '{8'd3, 3, {16'd0, 16'h0001, 16'h0002, 16'hFFFF}, 32'h10002, 32'hFFFF, 16'hFFFF, 16'h0001, 8'd3, 1'b0, 1'b1};
        vecs[5] = '{8'd4, 4, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 32'h3FFFC, 32'hFFFF, 16'hFFFF, 16'hFFFF, 8'd4, 1'b0, 1'b1};
        vecs[6] = '{8'd2, 2, {16'd0, 16'd0, 16'd2, 16'd1}, 32'd3, 32'd3, 16'd2, 16'd1, 8'd2, 1'b0, 1'b0};
        vecs[7] = '{8'd1, 1, {16'd0, 16'd0, 16'd0, 16'd0}, 32'd0, 32'd0, 16'd0, 16'd0, 8'd1, 1'b0, 1'b0};

        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        win_len   = '0;
        in_data   = '0;

        // Reset values
        #12;
        chk_flow("reset", 1'b0, 1'b0);
        chk("reset.sum0", 32'(b0.out_sum), 32'd0);
        chk("reset.max0", 32'(b0.out_max), 32'd0);
        chk("reset.min0", 32'(b0.out_min), 32'hFFFF);
        chk("reset.min1", 32'(b1.out_min), 32'hFFFF);
        chk("reset.cnt0", 32'(b0.out_cnt), 32'd0);
        chk("reset.ovf1", 32'(b1.out_ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_flow("release", 1'b0, 1'b1);

        // Table-driven windows with out_ready held high
        for (int v = 0; v < 8; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            feed(tag, vecs[v].len, vecs[v].n, vecs[v].s);
            check_res(tag, vecs[v].sum24, vecs[v].sum16, vecs[v].mx, vecs[v].mn,
                      vecs[v].cn, vecs[v].ovf24, vecs[v].ovf16);
            tick();
            chk_flow({tag, ".done"}, 1'b0, 1'b1);
        end

        // Backpressure: result held stable, input blocked
        out_ready = 1'b0;
        feed("bp", 8'd2, 2, {16'd0, 16'd0, 16'd42, 16'd36});
        check_res("bp", 32'd78, 32'd78, 16'd42, 16'd36, 8'd2, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 16'd99;
            tick();
            chk_flow("bp.hold", 1'b1, 1'b0);
            chk("bp.hold.sum0", 32'(b0.out_sum), 32'd78);
            chk("bp.hold.max1", 32'(b1.out_max), 32'd42);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk_flow("bp.release", 1'b0, 1'b1);

        // win_len change mid-window is ignored
        win_len  = 8'd4;
        in_valid = 1'b1;
        in_data  = 16'd1;
        tick();
        win_len = 8'd9;
        for (int i = 2; i <= 4; i++) begin
            in_data = 16'(i);
            tick();
        end
        in_valid = 1'b0;
        check_res("lenchg", 32'd10, 32'd10, 16'd4, 16'd1, 8'd4, 1'b0, 1'b0);
        tick();
        chk_flow("lenchg.done", 1'b0, 1'b1);

        // clear aborts a partial window and rejects the concurrent sample
        feed("clr.part", 8'd10, 3, {16'd0, 16'd30, 16'd20, 16'd10});
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'd500;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk_flow("clr", 1'b0, 1'b1);
        feed("clr.next", 8'd2, 2, {16'd0, 16'd0, 16'd54, 16'd48});
        check_res("clr.next", 32'd102, 32'd102, 16'd54, 16'd48, 8'd2, 1'b0, 1'b0);
        tick();

        // clear while holding a result drops out_valid, result values persist
        out_ready = 1'b0;
        feed("clrhold", 8'd1, 1, {16'd0, 16'd0, 16'd0, 16'd7});
        chk_flow("clrhold.pre", 1'b1, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk_flow("clrhold", 1'b0, 1'b1);
        chk("clrhold.sum0", 32'(b0.out_sum), 32'd7);

        // Asynchronous reset while holding a result
        feed("arst", 8'd2, 2, {16'd0, 16'd0, 16'd3, 16'd4});
        chk_flow("arst.pre", 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_flow("arst", 1'b0, 1'b0);
        chk("arst.min0", 32'(b0.out_min), 32'hFFFF);
        chk("arst.sum0", 32'(b0.out_sum), 32'd0);
        chk("arst.cnt1", 32'(b1.out_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk_flow("arst.release", 1'b0, 1'b1);
        feed("arst.next", 8'd2, 2, {16'd0, 16'd0, 16'd9, 16'd11});
        check_res("arst.next", 32'd20, 32'd20, 16'd11, 16'd9, 8'd2, 1'b0, 1'b0);
        tick();
        chk_flow("arst.done", 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sum_window_acc.md
Name: sum_window_acc

Overview:
Downstream consumer of the adder-chain stage that produces the 16-bit result stream f = c + d.
Accepts f samples over a valid/ready handshake and accumulates a programmable window of N samples.
Per window it reports the sum, max, min, sample count and a saturation flag on a registered valid/ready result port.
Sits between the adder-chain stage and the logging/checker stage.

Parameters:
DATA_W, 16, width of input samples (matches the f bus).
ACC_W, 24, width of the accumulated sum; must be >= DATA_W.
CNT_W, 8, width of window length and sample counter.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
clear  in  1  synchronous abort: discard partial window and any pending result.
win_len  in  CNT_W  window length; sampled on the first accepted sample of a window; 0 treated as 1.
in_valid  in  1  input sample valid.
in_ready  out  1  block can accept a sample.
in_data  in  DATA_W  input sample (unsigned).
out_valid  out  1  window result valid.
out_ready  in  1  downstream accepts result.
out_sum  out  ACC_W  window sum, saturating.
out_max  out  DATA_W  largest sample in window.
out_min  out  DATA_W  smallest sample in window.
out_cnt  out  CNT_W  samples accumulated (equals latched length).
out_ovf  out  1  sum saturated during this window.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. in_ready=0 during reset, 1 on the first clk after release. out_valid=0, out_sum=0, out_max=0, out_min=all-ones, out_cnt=0, out_ovf=0.
- A transfer happens on a rising clk edge with valid && ready. The data is unsigned, and every output is a register.
- in_ready is decoded from state only: 1 in IDLE and ACCUM, 0 in HOLD. There is no combinational path from out_ready to in_ready.
- State IDLE, on an input transfer:
  - latch len = (win_len==0 ? 1 : win_len); acc = in_data; max = min = in_data; cnt = 1; ovf = 0.
  - If len==1, go to HOLD; otherwise go to ACCUM.
- State ACCUM, on an input transfer:
  - acc = sat(acc + in_data). If the true sum exceeds 2^ACC_W-1, acc = 2^ACC_W-1 and ovf = 1 (sticky for the window).
  - Update max and min; cnt++.
  - When cnt reaches len, go to HOLD.
  - No transfer means the state holds with no change.
- State HOLD:
  - out_valid=1, and the outputs are driven from the window registers.
  - On out_valid && out_ready, go to IDLE; out_valid=0 on the next cycle.
  - Outputs stay stable while out_ready=0.
- Latency: out_valid rises on the cycle after the edge that accepted the last sample of the window. Minimum window period is len+1 cycles, because HOLD inserts one bubble even with out_ready tied high.
- out_* keep their last value after a handshake, until the next window completes. Downstream reads them only when out_valid=1.
- clear has the highest priority, above an input transfer or output transfer in the same cycle. It forces IDLE next cycle and drops out_valid, and a sample presented that cycle is not accepted.
- win_len changes mid-window are ignored; only the latched len is used.
- cnt cannot wrap, because len <= 2^CNT_W-1.
- Max/min comparisons are unsigned. On a tie, the value is unchanged.
- Mid-operation reset: asynchronous return to the reset values above, and the partial window is lost.

Decomposition:
- Shared package sum_pkg holds:
  - the DATA_W, ACC_W and CNT_W defaults;
  - the state enum typedef (IDLE, ACCUM, HOLD);
  - the function sat_add(acc, data), which returns {sum, ovf}.
- One natural sub-module, sum_minmax_track: registered max/min with an init strobe. The FSM, counter and accumulator live in the top.

Test Plan:
- Basic window: win_len=4, samples 12, 18, 24, 30 back-to-back, out_ready=1 -> out_valid one cycle after 30; out_sum=84, max=30, min=12, cnt=4, ovf=0.
- Backpressure: win_len=2, samples 36, 42, out_ready=0 for 5 cycles -> out_valid held with sum=78 stable; in_ready=0 throughout; release -> IDLE, in_ready=1 next cycle.
- Saturation: ACC_W=16, win_len=3, samples 0xFFFF, 0x0002, 0x0001 -> out_sum=0xFFFF, ovf=1, max=0xFFFF, min=0x0001.
- len edge cases: win_len=0 with sample 60 -> cnt=1, sum=60. win_len changed to 9 mid-window of 4 -> window still closes at 4.
- clear: win_len=10, 3 samples accepted, clear with in_valid=1 -> no acceptance that cycle. Next window of 2 samples 48, 54 -> sum=102, cnt=2.
- Async reset in HOLD: rst_n low between edges -> out_valid=0 and out_min=0xFFFF immediately; after release a fresh window accumulates correctly.
